aes_decrypt_iter: RTL
=====================

Name: aes_decrypt_iter

Overview:
- Iterative AES inverse cipher: one decryption round per clock, one shared round datapath.
- Parametrised for AES-128, AES-192 and AES-256.
- Latches a cipher key and decrypts a stream of 128-bit blocks under it, with valid/ready handshakes on input and output.
- Sits between the block-level stream interface and the codebase's combinational keyExpansion, inverseShiftRows, inverseSubBytes, inverseMixColumns and addRoundKey modules. It replaces a fully unrolled datapath where area matters more than throughput.

Parameters:
- N, 128: key width in bits; legal values are 128, 192 and 256.
- Nr, 10: number of rounds; must be 10, 12 or 14, matching N.
- Nk, 4: key length in 32-bit words; must be 4, 6 or 8, matching N.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- key  input  N  cipher key; sampled only when key_load is accepted.
- key_load  input  1  load request for key; accepted only in IDLE.
- in  input  128  ciphertext block.
- in_valid  input  1  in holds a valid block.
- in_ready  output  1  block can be accepted this cycle.
- out  output  128  plaintext block.
- out_valid  output  1  out holds a valid plaintext.
- out_ready  input  1  downstream accepts out.
- busy  output  1  high in the ROUND or DONE state.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; round counter to 0; state register to 0; key_reg to 0.
  - out goes to 0; out_valid to 0.
  - in_ready and busy are 0 while reset is high.
  - Reset mid-operation aborts the block in flight with no output produced. key_reg must be reloaded afterwards.
- Round keys: rk[0..Nr] come combinationally from keyExpansion applied to key_reg. rk[0] is the cipher key; rk[Nr] is the last encryption round key.
- FSM states:
  - IDLE:
    - in_ready = !key_load.
    - If key_load is high: key_reg <= key; stay in IDLE; no block is accepted that cycle, whatever in_valid is.
    - Else if in_valid is high: state <= in XOR rk[Nr]; rnd <= Nr-1; go to ROUND.
  - ROUND, with rnd >= 1:
    - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[rnd]).
    - rnd <= rnd-1.
  - ROUND, with rnd == 0:
    - out <= InvSubBytes(InvShiftRows(state)) XOR rk[0]; no InvMixColumns is applied.
    - out_valid <= 1; go to DONE.
  - DONE:
    - out and out_valid are held stable until out_ready is high.
    - On out_valid && out_ready: out_valid <= 0; go to IDLE. out keeps its last value.
- Timing:
  - Latency: out_valid rises Nr clock edges after the accepting edge (10, 12 or 14 cycles).
  - Throughput with out_ready tied high: one block every Nr+2 cycles.
- Handshake rules:
  - in_ready is 0 in ROUND and DONE; in_valid is ignored there.
  - key_load is ignored outside IDLE. key_reg never changes while a block is in flight.
  - A key loaded in cycle t is used for blocks accepted at t+1 or later.
- Width rules: rnd is $clog2(Nr+1) bits wide. All XORs are 128-bit with no carries.
- Byte order: bit 127 is byte 0, as in FIPS-197.

Test Plan:
- AES-128 (N=128, Nr=10, Nk=4): load key 000102030405060708090a0b0c0d0e0f, send in=69c4e0d86a7b0430d8cdb78070b4c55a -> out=00112233445566778899aabbccddeeff, with out_valid exactly 10 edges after acceptance.
- AES-192 (192, 12, 6): key 000102…1617, in=dda97ca4864cdfe06eaf70a0ec0d7191 -> out=00112233445566778899aabbccddeeff after 12 edges.
- AES-256 (256, 14, 8): key 000102…1e1f, in=8ea2b7ca516745bfeafc49904b496089 -> out=00112233445566778899aabbccddeeff after 14 edges.
- Back-pressure and rekey:
  - Hold out_ready=0 for 5 cycles after out_valid -> out is stable and in_ready stays 0.
  - Then pulse key_load with 2b7e151628aed2a6abf7158809cf4f3c together with in_valid -> the block is not accepted that cycle.
  - Next cycle, in=3925841d02dc09fbdc118597196a0b32 -> out=3243f6a8885a308d313198a2e0370734.
- Mid-block events:
  - Assert reset at round 5 of a block -> out_valid is never raised for that block; out=0 and key_reg=0 after reset.
  - key_load pulsed while busy -> ignored; the output matches the old key.
- Back-to-back streaming with out_ready=1 -> 4 blocks decrypted correctly, accepted every Nr+2 cycles.

Source files
------------

// File: rtl/aes_decrypt_iter_if.sv
// Block stream interface for the iterative AES decryptor: key load, ciphertext in, plaintext out.
interface aes_decrypt_iter_if #(
  parameter int N = 128
) ();
  logic [N-1:0] key;
  logic         key_load;
  logic [127:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output key, key_load, in, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  key, key_load, in, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 inverse cipher: one round per clock through a single shared round datapath.
module aes_decrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                clk,
  input  logic                reset,
  aes_decrypt_iter_if.slave   bus,
  output logic                busy
);

  localparam int RW = $clog2(Nr + 1);
  localparam int NW = 4 * (Nr + 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), built from a short square/multiply chain.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = a15;
    for (int i = 0; i < 4; i++) a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k sits at row k%4, column k/4; row r is rotated right by r positions.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  fsm_e          fsm_q, fsm_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [127:0]  state_q, state_d;
  logic [127:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  key_reg_q, key_reg_d;

  logic [127:0]  rk [Nr+1];
  logic [127:0]  round_in;

  // Forward key schedule; decryption walks rk from Nr down to 0.
  always_comb begin
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    t    = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = key_reg_q[N-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xtime(rcon);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
    end
    for (int r = 0; r <= Nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  assign round_in = inv_shift_sub(state_q) ^ rk[rnd_q];

  assign bus.in_ready  = !reset && (fsm_q == IDLE) && !bus.key_load;
  assign busy          = !reset && (fsm_q == ROUND || fsm_q == DONE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a value unassigned and infer a latch.
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    key_reg_d   = key_reg_q;
    case (fsm_q)
      IDLE: begin
        if (bus.key_load) begin
          key_reg_d = bus.key;
        end else if (bus.in_valid) begin
          state_d = bus.in ^ rk[Nr];
          rnd_d   = RW'(Nr - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q != '0) begin
          state_d = inv_mix_columns(round_in);
          rnd_d   = rnd_q - 1'b1;
        end else begin
          out_d       = round_in;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous, so it is just the first branch here.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      key_reg_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      key_reg_q   <= key_reg_d;
    end
  end

endmodule
